// File: rtl/sdram_init_sequencer.sv
// Power-up initialization sequencer for the SDR SDRAM controller.
// Sequence: power-up wait (CKE raised part-way through), PRECHARGE ALL,
// REFRESH_COUNT x AUTO REFRESH, then a mode-register handshake with the
// load-mode stage, re-requested on timeout. TRP and TRFC must be >= 1.
// All outputs are registered and decoded from the next state, so a command
// appears on the bus in the same cycle that the FSM enters its state.
module sdram_init_sequencer #(
   parameter int T_POWERUP     = 20000,
   parameter int CKE_DELAY     = 10000,
   parameter int TRP           = 2,
   parameter int TRFC          = 7,
   parameter int REFRESH_COUNT = 8,
   parameter int MODE_TIMEOUT  = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        mode_reg_done,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_addr,
   output logic        sdram_cke,
   output logic        sdram_init,
   output logic        mode_reg_en,
   output logic        init_done,
   output logic        init_error
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;

   // One shared wait counter, sized for the longest interval it must count.
   localparam int MAX_A   = (T_POWERUP > MODE_TIMEOUT) ? T_POWERUP : MODE_TIMEOUT;
   localparam int MAX_B   = (TRP > TRFC) ? TRP : TRFC;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int REF_W   = $clog2(REFRESH_COUNT + 1);

   localparam logic [CNT_W-1:0] CKE_AT      = CNT_W'(CKE_DELAY);
   localparam logic [CNT_W-1:0] POWERUP_END = CNT_W'(T_POWERUP);
   localparam logic [CNT_W-1:0] TRP_END     = CNT_W'(TRP - 1);
   localparam logic [CNT_W-1:0] TRFC_END    = CNT_W'(TRFC - 1);
   localparam logic [CNT_W-1:0] MODE_END    = CNT_W'(MODE_TIMEOUT);
   localparam logic [REF_W-1:0] REF_TOTAL   = REF_W'(REFRESH_COUNT);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_PRECHARGE,
      ST_WAIT_TRP,
      ST_REFRESH,
      ST_WAIT_TRFC,
      ST_MODE_REQ,
      ST_WAIT_MODE,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [1:0]       ba_q, ba_d;
   logic [11:0]      addr_q, addr_d;
   logic             cke_q, cke_d;
   logic             init_q, init_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // State, counters and registered outputs; reset returns to the power-up wait.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_POWERUP;
         cnt_q     <= '0;
         ref_cnt_q <= '0;
         cmd_q     <= CMD_NOP;
         ba_q      <= 2'b11;
         addr_q    <= 12'hfff;
         cke_q     <= 1'b0;
         init_q    <= 1'b0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ref_cnt_q <= ref_cnt_d;
         cmd_q     <= cmd_d;
         ba_q      <= ba_d;
         addr_q    <= addr_d;
         cke_q     <= cke_d;
         init_q    <= init_d;
         en_q      <= en_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic, then output decode from the next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      ref_cnt_d = ref_cnt_q;
      cke_d     = cke_q;
      err_d     = err_q;

      case (state_q)
         ST_POWERUP: begin
            if (cnt_q >= CKE_AT) cke_d = 1'b1;
            if (cnt_q == POWERUP_END) begin
               state_d = ST_PRECHARGE;
               cnt_d   = '0;
            end
         end
         ST_PRECHARGE: begin
            state_d = ST_WAIT_TRP;
            cnt_d   = '0;
         end
         ST_WAIT_TRP: begin
            if (cnt_q == TRP_END) begin
               state_d = ST_REFRESH;
               cnt_d   = '0;
            end
         end
         ST_REFRESH: begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
            state_d   = ST_WAIT_TRFC;
            cnt_d     = '0;
         end
         ST_WAIT_TRFC: begin
            if (cnt_q == TRFC_END) begin
               cnt_d   = '0;
               state_d = (ref_cnt_q < REF_TOTAL) ? ST_REFRESH : ST_MODE_REQ;
            end
         end
         ST_MODE_REQ: begin
            state_d = ST_WAIT_MODE;
            cnt_d   = '0;
         end
         ST_WAIT_MODE: begin
            // A completion in the timeout cycle still counts as success.
            if (mode_reg_done) begin
               state_d = ST_DONE;
            end else if (cnt_q == MODE_END) begin
               state_d = ST_MODE_REQ;
               err_d   = 1'b1;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase

      cmd_d  = CMD_NOP;
      ba_d   = 2'b11;
      addr_d = 12'hfff;
      if (state_d == ST_PRECHARGE) cmd_d = CMD_PRE;
      if (state_d == ST_REFRESH)   cmd_d = CMD_REF;
      en_d   = (state_d == ST_MODE_REQ);
      init_d = (state_d == ST_MODE_REQ) || (state_d == ST_WAIT_MODE);
      done_d = (state_d == ST_DONE);
   end

   assign sdram_cmd   = cmd_q;
   assign sdram_ba    = ba_q;
   assign sdram_addr  = addr_q;
   assign sdram_cke   = cke_q;
   assign sdram_init  = init_q;
   assign mode_reg_en = en_q;
   assign init_done   = done_q;
   assign init_error  = err_q;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Directed bench for sdram_init_sequencer. Two instances share clock and
// reset: u_nom (MODE_TIMEOUT=16) and u_to (MODE_TIMEOUT=4). Cycle n is the
// period after the n-th rising edge following reset release.
`timescale 1ns/1ps
module tb_sdram_init_sequencer;

   localparam logic [3:0]  NOP = 4'b0111;
   localparam logic [3:0]  PRE = 4'b0010;
   localparam logic [3:0]  REF = 4'b0001;
   localparam logic [22:0] RST_VEC = {4'b0111, 2'b11, 12'hfff, 5'b00000};
   // T_POWERUP + 1 + (1+TRP) + REFRESH_COUNT*(1+TRFC) + 1 + k, k = 6
   localparam int NOM_DONE_CYC = 20 + 1 + (1 + 2) + 2 * (1 + 3) + 1 + 6;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        nom_mrd, to_mrd;
   logic [3:0]  nom_cmd, to_cmd;
   logic [1:0]  nom_ba, to_ba;
   logic [11:0] nom_addr, to_addr;
   logic        nom_cke, to_cke;
   logic        nom_init, to_init;
   logic        nom_en, to_en;
   logic        nom_done, to_done;
   logic        nom_err, to_err;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   sdram_init_sequencer #(
      .T_POWERUP(20), .CKE_DELAY(10), .TRP(2), .TRFC(3), .REFRESH_COUNT(2), .MODE_TIMEOUT(16)
   ) u_nom (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_reg_done(nom_mrd),
      .sdram_cmd(nom_cmd), .sdram_ba(nom_ba), .sdram_addr(nom_addr), .sdram_cke(nom_cke),
      .sdram_init(nom_init), .mode_reg_en(nom_en), .init_done(nom_done), .init_error(nom_err)
   );

   sdram_init_sequencer #(
      .T_POWERUP(20), .CKE_DELAY(10), .TRP(2), .TRFC(3), .REFRESH_COUNT(2), .MODE_TIMEOUT(4)
   ) u_to (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_reg_done(to_mrd),
      .sdram_cmd(to_cmd), .sdram_ba(to_ba), .sdram_addr(to_addr), .sdram_cke(to_cke),
      .sdram_init(to_init), .mode_reg_en(to_en), .init_done(to_done), .init_error(to_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Expected command on the bus in cycle c for the bench parameters.
   function automatic logic [3:0] exp_cmd(input int c);
      if (c == 21) return PRE;
      if (c == 24 || c == 28) return REF;
      return NOP;
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      nom_mrd   = 1'b0;
      to_mrd    = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      nom_mrd   = 1'b0;
      to_mrd    = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      vec_cnt++;
      if ({nom_cmd, nom_ba, nom_addr, nom_cke, nom_init, nom_en, nom_done, nom_err} !== RST_VEC) begin
         $display("FAIL reset_nom: got %h want %h",
                  {nom_cmd, nom_ba, nom_addr, nom_cke, nom_init, nom_en, nom_done, nom_err}, RST_VEC);
         err_cnt++;
      end
      vec_cnt++;
      if ({to_cmd, to_ba, to_addr, to_cke, to_init, to_en, to_done, to_err} !== RST_VEC) begin
         $display("FAIL reset_to: got %h want %h",
                  {to_cmd, to_ba, to_addr, to_cke, to_init, to_en, to_done, to_err}, RST_VEC);
         err_cnt++;
      end
   endtask

   task automatic test_cke_timing();
      do_reset();
      for (int i = 1; i <= 21; i++) begin
         step();
         vec_cnt++;
         if (nom_cke !== (cyc >= 11)) begin
            $display("FAIL cke cyc=%0d: got %b want %b", cyc, nom_cke, (cyc >= 11));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_cmd !== exp_cmd(cyc)) begin
            $display("FAIL early_cmd cyc=%0d: got %b want %b", cyc, nom_cmd, exp_cmd(cyc));
            err_cnt++;
         end
      end
      vec_cnt++;
      if (nom_addr !== 12'hfff) begin
         $display("FAIL precharge_addr: got %h want fff", nom_addr);
         err_cnt++;
      end
   endtask

   task automatic test_nominal();
      do_reset();
      for (int i = 1; i <= 45; i++) begin
         step();
         nom_mrd = (cyc == 38);
         vec_cnt++;
         if (nom_cmd !== exp_cmd(cyc)) begin
            $display("FAIL nominal_cmd cyc=%0d: got %b want %b", cyc, nom_cmd, exp_cmd(cyc));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_en !== (cyc == 32)) begin
            $display("FAIL nominal_en cyc=%0d: got %b want %b", cyc, nom_en, (cyc == 32));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_init !== (cyc >= 32 && cyc < NOM_DONE_CYC)) begin
            $display("FAIL nominal_init cyc=%0d: got %b", cyc, nom_init);
            err_cnt++;
         end
         vec_cnt++;
         if (nom_done !== (cyc >= NOM_DONE_CYC)) begin
            $display("FAIL nominal_done cyc=%0d: got %b want %b", cyc, nom_done, (cyc >= NOM_DONE_CYC));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_err !== 1'b0) begin
            $display("FAIL nominal_err cyc=%0d: got %b want 0", cyc, nom_err);
            err_cnt++;
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= 45; i++) begin
         step();
         to_mrd = (cyc == 40);
         vec_cnt++;
         if (to_en !== (cyc == 32 || cyc == 38)) begin
            $display("FAIL timeout_en cyc=%0d: got %b want %b", cyc, to_en, (cyc == 32 || cyc == 38));
            err_cnt++;
         end
         vec_cnt++;
         if (to_err !== (cyc >= 38)) begin
            $display("FAIL timeout_err cyc=%0d: got %b want %b", cyc, to_err, (cyc >= 38));
            err_cnt++;
         end
         vec_cnt++;
         if (to_done !== (cyc >= 41)) begin
            $display("FAIL timeout_done cyc=%0d: got %b want %b", cyc, to_done, (cyc >= 41));
            err_cnt++;
         end
         vec_cnt++;
         if (to_init !== (cyc >= 32 && cyc <= 40)) begin
            $display("FAIL timeout_init cyc=%0d: got %b", cyc, to_init);
            err_cnt++;
         end
      end
      // Asynchronous reset from DONE with the error flag set clears both flags.
      sys_rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({to_cmd, to_ba, to_addr, to_cke, to_init, to_en, to_done, to_err} !== RST_VEC) begin
         $display("FAIL reset_from_done: got %h want %h",
                  {to_cmd, to_ba, to_addr, to_cke, to_init, to_en, to_done, to_err}, RST_VEC);
         err_cnt++;
      end
   endtask

   task automatic test_spurious_done();
      do_reset();
      for (int i = 1; i <= 42; i++) begin
         step();
         nom_mrd = (cyc == 5 || cyc == 26 || cyc == 38);
         vec_cnt++;
         if (nom_cmd !== exp_cmd(cyc)) begin
            $display("FAIL spurious_cmd cyc=%0d: got %b want %b", cyc, nom_cmd, exp_cmd(cyc));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_en !== (cyc == 32)) begin
            $display("FAIL spurious_en cyc=%0d: got %b want %b", cyc, nom_en, (cyc == 32));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_done !== (cyc >= 39)) begin
            $display("FAIL spurious_done cyc=%0d: got %b want %b", cyc, nom_done, (cyc >= 39));
            err_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid_refresh();
      do_reset();
      for (int i = 1; i <= 30; i++) begin
         step();
      end
      // Cycle 30 lies in the second WAIT_TRFC; reset must act without a clock edge.
      sys_rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({nom_cmd, nom_ba, nom_addr, nom_cke, nom_init, nom_en, nom_done, nom_err} !== RST_VEC) begin
         $display("FAIL mid_reset: got %h want %h",
                  {nom_cmd, nom_ba, nom_addr, nom_cke, nom_init, nom_en, nom_done, nom_err}, RST_VEC);
         err_cnt++;
      end
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         nom_mrd = (cyc == 38);
         vec_cnt++;
         if (nom_cmd !== exp_cmd(cyc)) begin
            $display("FAIL restart_cmd cyc=%0d: got %b want %b", cyc, nom_cmd, exp_cmd(cyc));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_cke !== (cyc >= 11)) begin
            $display("FAIL restart_cke cyc=%0d: got %b want %b", cyc, nom_cke, (cyc >= 11));
            err_cnt++;
         end
         vec_cnt++;
         if (nom_done !== (cyc >= 39)) begin
            $display("FAIL restart_done cyc=%0d: got %b want %b", cyc, nom_done, (cyc >= 39));
            err_cnt++;
         end
      end
   endtask

   task automatic test_collision();
      do_reset();
      for (int i = 1; i <= 50; i++) begin
         step();
         // Sampled at edge 38, the same edge at which the timeout expires.
         to_mrd = (cyc == 37);
         vec_cnt++;
         if (to_en !== (cyc == 32)) begin
            $display("FAIL collision_en cyc=%0d: got %b want %b", cyc, to_en, (cyc == 32));
            err_cnt++;
         end
         vec_cnt++;
         if (to_done !== (cyc >= 38)) begin
            $display("FAIL collision_done cyc=%0d: got %b want %b", cyc, to_done, (cyc >= 38));
            err_cnt++;
         end
         vec_cnt++;
         if (to_err !== 1'b0) begin
            $display("FAIL collision_err cyc=%0d: got %b want 0", cyc, to_err);
            err_cnt++;
         end
         vec_cnt++;
         if (to_init !== (cyc >= 32 && cyc <= 37)) begin
            $display("FAIL collision_init cyc=%0d: got %b", cyc, to_init);
            err_cnt++;
         end
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      nom_mrd   = 1'b0;
      to_mrd    = 1'b0;
      test_reset();
      test_cke_timing();
      test_nominal();
      test_timeout();
      test_spurious_done();
      test_reset_mid_refresh();
      test_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
